// File: rtl/spi_master_engine.sv
// SPI master shift engine: pulls bytes from the TX FIFO (or sends 0xFF),
// shifts them out on SCLK/MOSI, and pushes received bytes into the RX FIFO.
module spi_master_engine #(
    parameter int C_DATA_WIDTH = 32,
    parameter int MIN_DIV      = 5
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    spi_ena,
    input  logic                    tx_sel,
    input  logic [C_DATA_WIDTH-1:0] fifo_rdata,
    output logic                    fifo_rena,
    output logic [C_DATA_WIDTH-1:0] fifo_wdata,
    output logic                    fifo_wena,
    output logic                    spi_busy,
    input  logic                    msb_first,
    input  logic                    delay_byte,
    input  logic                    cpol,
    input  logic                    cpha,
    input  logic [7:0]              n_delay_byte,
    input  logic [23:0]             clk_div,
    output logic                    sclk,
    output logic                    cs_n,
    output logic                    mosi,
    input  logic                    miso
);

    localparam logic [23:0] MIN_HDIV = 24'(MIN_DIV);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT, BYTE_END, GAP, FINISH
    } state_t;

    state_t      state, state_nx;
    logic [23:0] hdiv, hdiv_in, cnt;
    logic [4:0]  edge_cnt;
    logic [1:0]  bend_cnt;
    logic [32:0] gap_cnt, gap_last;
    logic        cpol_l, cpha_l, msb_l, dly_l, btx_sel;
    logic [7:0]  ndly_l;
    logic [7:0]  tx_shift, rx_shift, rx_next, byte_in;
    logic        sclk_r, mosi_r;
    logic [C_DATA_WIDTH-1:0] wdata_r;
    logic        half_done, first_setup, edge_now, last_edge, sample, shift_tx;

    assign hdiv_in     = (clk_div < MIN_HDIV) ? MIN_HDIV : clk_div;
    assign half_done   = (cnt == hdiv - 24'd1);
    assign gap_last    = 33'({ndly_l, 1'b0}) * 33'(hdiv) - 33'd1;
    assign first_setup = (state == SETUP) && (cnt == '0);
    // edge 1 fires on the SETUP->SHIFT boundary, edges 2..16 inside SHIFT
    assign edge_now    = half_done && ((state == SETUP) || (state == SHIFT));
    assign last_edge   = edge_now && (state == SHIFT) && (edge_cnt == 5'd15);
    // edge_cnt holds edges already done, so edge_cnt[0]==0 means an odd edge
    assign sample      = edge_now && (cpha_l ? edge_cnt[0] : ~edge_cnt[0]);
    assign shift_tx    = edge_now && (cpha_l ? ~edge_cnt[0]
                                             : (edge_cnt[0] && (edge_cnt != 5'd15)));
    assign byte_in     = tx_sel ? fifo_rdata[7:0] : 8'hFF;
    assign rx_next     = msb_l ? {rx_shift[6:0], miso} : {miso, rx_shift[7:1]};

    assign cs_n       = (state == IDLE);
    assign spi_busy   = (state != IDLE);
    assign sclk       = sclk_r;
    assign mosi       = mosi_r;
    assign fifo_wdata = wdata_r;
    assign fifo_rena  = first_setup && tx_sel;
    assign fifo_wena  = (state == BYTE_END) && (bend_cnt == 2'd0) && !btx_sel;

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (spi_ena) state_nx = SETUP;
            SETUP:    if (half_done) state_nx = SHIFT;
            SHIFT:    if (last_edge) state_nx = BYTE_END;
            BYTE_END: if (bend_cnt == 2'd2) begin
                          if (!spi_ena)                          state_nx = FINISH;
                          else if (dly_l && (ndly_l != 8'd0))    state_nx = GAP;
                          else                                   state_nx = SETUP;
                      end
            GAP:      if (gap_cnt == gap_last) state_nx = SETUP;
            FINISH:   if (half_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    // Configuration snapshot taken when a transaction starts
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cpol_l <= 1'b0;
            cpha_l <= 1'b0;
            msb_l  <= 1'b0;
            dly_l  <= 1'b0;
            ndly_l <= '0;
            hdiv   <= MIN_HDIV;
        end else if ((state == IDLE) && spi_ena) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
            msb_l  <= msb_first;
            dly_l  <= delay_byte;
            ndly_l <= n_delay_byte;
            hdiv   <= hdiv_in;
        end
    end

    // Half-period, edge, byte-end and gap counters
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt      <= '0;
            edge_cnt <= '0;
            bend_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if ((state_nx != state) || half_done ||
                !((state == SETUP) || (state == SHIFT) || (state == FINISH)))
                cnt <= '0;
            else
                cnt <= cnt + 24'd1;
            if (first_setup)   edge_cnt <= '0;
            else if (edge_now) edge_cnt <= edge_cnt + 5'd1;
            bend_cnt <= ((state == BYTE_END) && (state_nx == BYTE_END)) ? bend_cnt + 2'd1 : '0;
            gap_cnt  <= ((state == GAP) && (state_nx == GAP)) ? gap_cnt + 33'd1 : '0;
        end
    end

    // SCLK generation and MOSI shifting
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b0;
            tx_shift <= '0;
            btx_sel  <= 1'b0;
        end else begin
            if (state == IDLE)  sclk_r <= cpol;
            else if (edge_now)  sclk_r <= ~sclk_r;
            // CPHA=0 presents bit 0 of the order now and pre-shifts; CPHA=1
            // keeps the byte whole so edge 1 emits the first bit.
            if (first_setup) begin
                btx_sel  <= tx_sel;
                mosi_r   <= msb_l ? byte_in[7] : byte_in[0];
                tx_shift <= cpha_l ? byte_in
                          : (msb_l ? {byte_in[6:0], 1'b0} : {1'b0, byte_in[7:1]});
            end else if (shift_tx) begin
                mosi_r   <= msb_l ? tx_shift[7] : tx_shift[0];
                tx_shift <= msb_l ? {tx_shift[6:0], 1'b0} : {1'b0, tx_shift[7:1]};
            end
        end
    end

    // MISO assembly and RX word capture at edge 16
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_shift <= '0;
            wdata_r  <= '0;
        end else begin
            if (sample) rx_shift <= rx_next;
            if (last_edge && !btx_sel)
                wdata_r <= {{(C_DATA_WIDTH-8){1'b0}}, (sample ? rx_next : rx_shift)};
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine with hand-computed expectations.
module tb_spi_master_engine;

    logic        clk = 1'b0;
    logic        nrst, spi_ena, tx_sel, fifo_rena, fifo_wena, spi_busy;
    logic [31:0] fifo_rdata, fifo_wdata;
    logic        msb_first, delay_byte, cpol, cpha;
    logic [7:0]  n_delay_byte;
    logic [23:0] clk_div, div_mid;
    logic        sclk, cs_n, mosi, miso;

    spi_master_engine #(.C_DATA_WIDTH(32), .MIN_DIV(5)) dut (
        .clk(clk), .nrst(nrst), .spi_ena(spi_ena), .tx_sel(tx_sel),
        .fifo_rdata(fifo_rdata), .fifo_rena(fifo_rena), .fifo_wdata(fifo_wdata),
        .fifo_wena(fifo_wena), .spi_busy(spi_busy), .msb_first(msb_first),
        .delay_byte(delay_byte), .cpol(cpol), .cpha(cpha),
        .n_delay_byte(n_delay_byte), .clk_div(clk_div), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // capture results of one transaction (n counts negedges after spi_ena is driven)
    int          cs_rise, low_cnt, rena_cnt, wena_cnt, rise_cnt, last_tog;
    int          busy_bad = 0;
    int          both_cnt = 0;
    int          rena_n[4], wena_n[4], rise_n[20];
    logic [31:0] wdata_q[4];
    logic [15:0] mosi_bits;
    logic [7:0]  tx_bytes[2];
    logic [7:0]  miso_pat;
    int          miso_idx, drop_evt, drop_rise;

    task automatic drive_miso();
        logic [2:0] bi;
        bi   = 3'(miso_idx);
        miso = msb_first ? miso_pat[3'd7 - bi] : miso_pat[bi];
    endtask

    task automatic run_txn(input bit rel, input int budget);
        int  n;
        bit  seen_low, done, pop_pend, prev_sclk;
        cs_rise = 0; low_cnt = 0; rena_cnt = 0; wena_cnt = 0; rise_cnt = 0;
        last_tog = 0; mosi_bits = '0; miso_idx = 0;
        drive_miso();
        fifo_rdata = {24'h0, tx_bytes[0]};
        @(negedge clk);
        if (rel) nrst = 1'b1;
        spi_ena = 1'b1;
        n = 0; seen_low = 0; done = 0; pop_pend = 0; prev_sclk = sclk;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (pop_pend) begin
                fifo_rdata = {24'h0, tx_bytes[(rena_cnt < 2) ? rena_cnt : 1]};
                pop_pend   = 0;
            end
            if (cs_n == 1'b0) begin
                low_cnt++;
                seen_low = 1;
            end else if (seen_low) begin
                cs_rise = n;
                done    = 1;
            end
            if (spi_busy !== !cs_n) busy_bad++;
            if (fifo_rena && fifo_wena) both_cnt++;
            if (fifo_rena) begin
                if (rena_cnt < 4) rena_n[rena_cnt] = n;
                rena_cnt++;
                pop_pend = 1;
                clk_div  = div_mid;
            end
            if (fifo_wena) begin
                if (wena_cnt < 4) begin
                    wena_n[wena_cnt]  = n;
                    wdata_q[wena_cnt] = fifo_wdata;
                end
                wena_cnt++;
            end
            if (sclk !== prev_sclk) begin
                last_tog = n;
                if (sclk) begin
                    if (rise_cnt < 20) rise_n[rise_cnt] = n;
                    rise_cnt++;
                    mosi_bits = {mosi_bits[14:0], mosi};
                    miso_idx++;
                    drive_miso();
                end
            end
            prev_sclk = sclk;
            if ((drop_evt != 0 && (rena_cnt + wena_cnt) >= drop_evt) ||
                (drop_rise != 0 && rise_cnt >= drop_rise))
                spi_ena = 1'b0;
        end
        check("txn_done", 32'(done), 32'd1);
        spi_ena = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; spi_ena = 1'b0; tx_sel = 1'b1; fifo_rdata = '0;
        msb_first = 1'b1; delay_byte = 1'b0; cpol = 1'b0; cpha = 1'b0;
        n_delay_byte = 8'd0; clk_div = 24'd5; div_mid = 24'd5; miso = 1'b0;
        miso_pat = 8'h00; drop_evt = 1; drop_rise = 0;
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00;

        #12;
        check("rst_cs_n",  32'(cs_n),  32'd1);
        check("rst_sclk",  32'(sclk),  32'd0);
        check("rst_mosi",  32'(mosi),  32'd0);
        check("rst_busy",  32'(spi_busy), 32'd0);
        check("rst_rena",  32'(fifo_rena), 32'd0);
        check("rst_wena",  32'(fifo_wena), 32'd0);
        check("rst_wdata", fifo_wdata, 32'd0);
        @(negedge clk); nrst = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0, MSB first, 0xA5, single byte
        tx_bytes[0] = 8'hA5;
        run_txn(1'b0, 400);
        check("m0_mosi",     32'(mosi_bits[7:0]), 32'hA5);
        check("m0_rises",    32'(rise_cnt), 32'd8);
        check("m0_first_rise", 32'(rise_n[0]), 32'd6);
        check("m0_rena",     32'(rena_cnt), 32'd1);
        check("m0_rena_n",   32'(rena_n[0]), 32'd1);
        check("m0_wena",     32'(wena_cnt), 32'd0);
        check("m0_cs_rise",  32'(cs_rise), 32'd89);
        check("m0_cs_low",   32'(low_cnt), 32'd88);

        // clk_div=2 clamps to 5; change to 8 mid-transaction is ignored
        repeat (2) @(negedge clk);
        clk_div = 24'd2; div_mid = 24'd8;
        run_txn(1'b0, 400);
        check("clamp_first_rise", 32'(rise_n[0]), 32'd6);
        check("clamp_rise_span",  32'(rise_n[7] - rise_n[0]), 32'd70);
        check("clamp_cs_rise",    32'(cs_rise), 32'd89);
        // next transaction picks up clk_div=8
        repeat (2) @(negedge clk);
        run_txn(1'b0, 400);
        check("div8_first_rise", 32'(rise_n[0]), 32'd9);
        check("div8_cs_rise",    32'(cs_rise), 32'd140);

        // mode 3, LSB first, RX only, two bytes, MISO = 0x3C
        repeat (2) @(negedge clk);
        clk_div = 24'd5; div_mid = 24'd5;
        cpol = 1'b1; cpha = 1'b1; msb_first = 1'b0; tx_sel = 1'b0;
        miso_pat = 8'h3C; drop_evt = 2;
        repeat (2) @(negedge clk);
        check("m3_idle_sclk", 32'(sclk), 32'd1);
        run_txn(1'b0, 400);
        check("m3_mosi",     32'(mosi_bits), 32'hFFFF);
        check("m3_rises",    32'(rise_cnt), 32'd16);
        check("m3_rena",     32'(rena_cnt), 32'd0);
        check("m3_wena",     32'(wena_cnt), 32'd2);
        check("m3_wdata0",   wdata_q[0], 32'h0000003C);
        check("m3_wdata1",   wdata_q[1], 32'h0000003C);
        check("m3_wena_n0",  32'(wena_n[0]), 32'd81);
        check("m3_spacing",  32'(wena_n[1] - wena_n[0]), 32'd83);
        check("m3_cs_rise",  32'(cs_rise), 32'd172);

        // inter-byte gap: hdiv 6, 3 SCLK periods
        repeat (2) @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; tx_sel = 1'b1;
        delay_byte = 1'b1; n_delay_byte = 8'd3; clk_div = 24'd6; div_mid = 24'd6;
        tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34; drop_evt = 2;
        repeat (2) @(negedge clk);
        run_txn(1'b0, 600);
        check("gap_rena",    32'(rena_cnt), 32'd2);
        check("gap_spacing", 32'(rena_n[1] - rena_n[0]), 32'd135);
        check("gap_mosi",    32'(mosi_bits), 32'h1234);
        check("gap_cs_rise", 32'(cs_rise), 32'd241);

        // spi_ena dropped during SHIFT: byte completes, no second pop
        repeat (2) @(negedge clk);
        delay_byte = 1'b0; n_delay_byte = 8'd0; clk_div = 24'd5; div_mid = 24'd5;
        tx_bytes[0] = 8'h5A; drop_evt = 0; drop_rise = 2;
        run_txn(1'b0, 400);
        check("drop_rena",    32'(rena_cnt), 32'd1);
        check("drop_mosi",    32'(mosi_bits[7:0]), 32'h5A);
        check("drop_tail",    32'(cs_rise - last_tog), 32'd8);
        check("drop_cs_rise", 32'(cs_rise), 32'd89);

        // asynchronous reset mid-SHIFT, then clean restart
        repeat (2) @(negedge clk);
        drop_rise = 0; drop_evt = 1; tx_bytes[0] = 8'h81;
        spi_ena = 1'b1;
        repeat (30) @(negedge clk);
        check("pre_rst_sclk", 32'(sclk), 32'd1);
        check("pre_rst_cs_n", 32'(cs_n), 32'd0);
        #2 nrst = 1'b0;
        #1;
        check("mid_rst_cs_n",  32'(cs_n), 32'd1);
        check("mid_rst_sclk",  32'(sclk), 32'd0);
        check("mid_rst_busy",  32'(spi_busy), 32'd0);
        check("mid_rst_mosi",  32'(mosi), 32'd0);
        check("mid_rst_wdata", fifo_wdata, 32'd0);
        run_txn(1'b1, 400);
        check("rst_new_rena",    32'(rena_cnt), 32'd1);
        check("rst_new_rena_n",  32'(rena_n[0]), 32'd1);
        check("rst_new_mosi",    32'(mosi_bits[7:0]), 32'h81);
        check("rst_new_cs_rise", 32'(cs_rise), 32'd89);

        check("busy_tracks_cs", 32'(busy_bad), 32'd0);
        check("rena_wena_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_engine.md
# spi_master_engine

SPI master shift engine sitting below the AXI4-Lite SPI FIFO bridge. It consumes the bridge's TX FIFO read port, configuration outputs and `spi_ena`, and drives the SPI pins. It pushes received bytes into the bridge's RX FIFO write port and reports `spi_busy` back to the bridge's SPI sequencer. One FIFO word carries one byte in bits [7:0].

## Interface
- `C_DATA_WIDTH`, default 32: FIFO word width; must be ≥ 8.
- `MIN_DIV`, default 5: minimum effective `clk_div`.

Ports:
- `clk` — in, 1: clock.
- `nrst` — in, 1: reset, asynchronous, active-low.
- `spi_ena` — in, 1: transaction request/continue from the bridge.
- `tx_sel` — in, 1: 1 = byte from TX FIFO, no RX push; 0 = send 0xFF, push RX.
- `fifo_rdata` — in, C_DATA_WIDTH: TX FIFO head (combinational, valid every cycle).
- `fifo_rena` — out, 1: TX FIFO pop, one-cycle pulse.
- `fifo_wdata` — out, C_DATA_WIDTH: received byte, zero-extended.
- `fifo_wena` — out, 1: RX FIFO push, one-cycle pulse.
- `spi_busy` — out, 1: engine not idle.
- `msb_first`, `delay_byte`, `cpol`, `cpha` — in, 1 each: configuration.
- `n_delay_byte` — in, 8: inter-byte gap in SCLK periods.
- `clk_div` — in, 24: SCLK half-period in clk cycles.
- `sclk`, `cs_n`, `mosi` — out, 1 each: SPI pins.
- `miso` — in, 1: SPI data in.

## Operation
- **FSM states:** IDLE, SETUP, SHIFT, BYTE_END, GAP, FINISH.
- **IDLE:**
  - `cs_n`=1, `sclk`=`cpol` (live), `spi_busy`=0.
  - On `spi_ena`=1:
    - latch `cpol`/`cpha`/`msb_first`/`delay_byte`/`n_delay_byte`;
    - latch `hdiv` = max(`clk_div`, MIN_DIV);
    - go to SETUP.
  - Mid-transaction configuration changes are ignored.
- **SETUP** (entered from IDLE or GAP):
  - Load byte: if `tx_sel`, load `fifo_rdata[7:0]` and pulse `fifo_rena` in this first cycle; otherwise load 0xFF.
  - Drive `cs_n`=0 and `mosi` with the first bit (bit 7 if `msb_first`, else bit 0).
  - Wait `hdiv` cycles, then go to SHIFT.
- **SHIFT:**
  - 16 SCLK edges, one every `hdiv` cycles; `sclk` toggles at each edge.
  - CPHA=0: sample `miso` on odd edges (leading); shift `mosi` to the next bit on even edges 2..14. Edge 16 does not shift.
  - CPHA=1: shift `mosi` on odd edges (including edge 1; the SETUP bit is don't-care); sample on even edges.
  - Received bits are assembled in the `msb_first` order.
  - After edge 16, `sclk` is back at latched `cpol`; go to BYTE_END.
- **BYTE_END** (3 cycles):
  - Cycle 0: if the byte's latched `tx_sel`=0, set `fifo_wdata`={0, rx_byte} and pulse `fifo_wena`.
  - Cycle 2: evaluate `spi_ena`. This gives the bridge time to update `spi_ena` after the push/pop.
  - If `spi_ena`=1: go to GAP when `delay_byte`=1 and `n_delay_byte`≠0, else go to SETUP.
  - If `spi_ena`=0: go to FINISH.
- **GAP:** `cs_n`=0, `sclk` idle, for `n_delay_byte`×2×`hdiv` cycles; then go to SETUP.
- **FINISH:** hold `cs_n`=0 for `hdiv` cycles, then `cs_n`=1; go to IDLE.
- **`spi_busy`:** 1 in every state except IDLE.
- **`fifo_wdata`:** holds its value between pushes.
- **Counters:**
  - Half-period counter is 24 bits.
  - Gap counter is 33 bits (8+1+24); no overflow at `n_delay_byte`=255, `hdiv`=2^24−1.
- **Boundary conditions:**
  - An empty TX FIFO is the bridge's responsibility; the engine pops unconditionally when `tx_sel`=1 at SETUP.
  - A `spi_ena` drop during SHIFT/GAP does not abort; the current byte/gap completes.
- **Reset (any time, asynchronous):**
  - `cs_n`=1, `sclk`=0, `mosi`=0, `fifo_rena`=0, `fifo_wena`=0, `fifo_wdata`=0, `spi_busy`=0, state IDLE.
  - Latched configuration resets to 0; `hdiv` resets to MIN_DIV.

## Timing
- `spi_ena` seen at edge t → SETUP at t+1 (`cs_n` low and `fifo_rena` high at t+1). First SCLK edge at t+1+`hdiv`.
- Byte duration, SETUP start to BYTE_END entry: 16×`hdiv` cycles.
- Consecutive bytes without gap: byte start-to-start = 16×`hdiv`+3 cycles.
- `fifo_rena` and `fifo_wena` never assert in the same cycle.
- Last SCLK edge to `cs_n` rise: 3+`hdiv` cycles.

## Test plan
- Mode 0, MSB first, `clk_div`=5, `tx_sel`=1, `fifo_rdata`=0xA5, `spi_ena` drops after one pop:
  - `mosi` sampled at the 8 rising edges = 1,0,1,0,0,1,0,1;
  - exactly one `fifo_rena`; no `fifo_wena`;
  - `cs_n` low for 80+3+5 cycles plus 1 SETUP offset.
- Mode 3, LSB first, `tx_sel`=0, `miso` driven to 0x3C (LSB first), two bytes:
  - `mosi` all ones;
  - two `fifo_wena` pulses, each with `fifo_wdata`=0x0000003C.
- `delay_byte`=1, `n_delay_byte`=3, `clk_div`=6, two TX bytes → byte-to-byte start spacing = 96+3+36 = 135 cycles.
- `clk_div`=2 → half-period = 5 cycles (clamped). Changing `clk_div` to 8 mid-transaction leaves the period unchanged until the next IDLE→SETUP.
- `spi_ena` deasserted during SHIFT of byte 0 → byte completes, `cs_n` rises `hdiv`+3 cycles after edge 16, `spi_busy` falls in the same cycle, no second pop.
- `nrst` asserted mid-SHIFT → same-cycle `cs_n`=1, `sclk`=0, `spi_busy`=0. After release with `spi_ena`=1, a clean new transaction starts from SETUP.
